// File: rtl/master_addr_tx.sv
// Master-side device-address transmitter: serializes a captured address LSB-first,
// waits for the decoder ack, then connects the data path and tracks split/resume.
module master_addr_tx #(
  parameter int DEVICE_ADDR_WIDTH = 4,
  parameter int ACK_TIMEOUT       = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req,
  input  logic [DEVICE_ADDR_WIDTH-1:0] dev_addr,
  input  logic                         dp_valid,
  input  logic                         dp_wdata,
  input  logic                         dp_done,
  input  logic                         ack,
  input  logic                         ssplit,
  input  logic                         split_grant,
  output logic                         mvalid,
  output logic                         mwdata,
  output logic                         busy,
  output logic                         connected,
  output logic                         done,
  output logic                         err
);

  localparam int CNT_W = $clog2(DEVICE_ADDR_WIDTH) + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEVICE_ADDR_WIDTH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_ACKWAIT = 3'd2,
    S_CONNECT = 3'd3,
    S_SPLIT   = 3'd4
  } state_t;

  state_t                       r_state;
  logic [DEVICE_ADDR_WIDTH-1:0] r_addr_q;
  logic [CNT_W-1:0]             r_cnt;
  logic [TMR_W-1:0]             r_timer;
  logic                         r_done;
  logic                         r_err;

  logic [DEVICE_ADDR_WIDTH-1:0] w_addr_shift;
  logic                         w_mvalid;
  logic                         w_mwdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_addr_q <= '0;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr_q <= dev_addr;
            r_cnt    <= '0;
            r_state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_timer <= '0;
            r_state <= S_ACKWAIT;
          end
        end
        S_ACKWAIT: begin
          // An ack on the final wait cycle still wins over the timeout.
          if (ack) begin
            r_state <= S_CONNECT;
          end else if (r_timer == TMR_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_CONNECT: begin
          if (dp_done) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (ssplit) begin
            r_state <= S_SPLIT;
          end
        end
        S_SPLIT: begin
          // Resume straight into CONNECT; the decoder remembers the slave.
          if (split_grant) begin
            r_state <= S_CONNECT;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_addr_shift = r_addr_q >> r_cnt;

  always_comb begin
    w_mvalid = 1'b0;
    w_mwdata = 1'b0;
    case (r_state)
      S_ADDR: begin
        // Only the first address bit is flagged as the decoder start bit.
        w_mvalid = (r_cnt == '0);
        w_mwdata = w_addr_shift[0];
      end
      S_CONNECT: begin
        w_mvalid = dp_valid;
        w_mwdata = dp_wdata;
      end
      default: begin
        w_mvalid = 1'b0;
        w_mwdata = 1'b0;
      end
    endcase
  end

  assign mvalid    = w_mvalid;
  assign mwdata    = w_mwdata;
  assign busy      = (r_state != S_IDLE);
  assign connected = (r_state == S_CONNECT);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_master_addr_tx.sv
// Directed bench for master_addr_tx: normal, timeout, late ack, split/resume,
// done-vs-split priority, ignored req and asynchronous reset mid-address.
module tb_master_addr_tx;

  localparam int W = 4;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req;
  logic [W-1:0] dev_addr;
  logic         dp_valid;
  logic         dp_wdata;
  logic         dp_done;
  logic         ack;
  logic         ssplit;
  logic         split_grant;
  logic         mvalid;
  logic         mwdata;
  logic         busy;
  logic         connected;
  logic         done;
  logic         err;

  int n_chk = 0;
  int n_err = 0;

  master_addr_tx #(
    .DEVICE_ADDR_WIDTH(W),
    .ACK_TIMEOUT      (T)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .dev_addr   (dev_addr),
    .dp_valid   (dp_valid),
    .dp_wdata   (dp_wdata),
    .dp_done    (dp_done),
    .ack        (ack),
    .ssplit     (ssplit),
    .split_grant(split_grant),
    .mvalid     (mvalid),
    .mwdata     (mwdata),
    .busy       (busy),
    .connected  (connected),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Launches a request and checks the serialized bits; returns in the first ACKWAIT cycle.
  task automatic send_addr(input logic [W-1:0] a, input bit inject);
    dev_addr = a;
    req      = 1'b1;
    tick();
    req      = 1'b0;
    dev_addr = '0;
    for (int i = 0; i < W; i++) begin
      if (inject) begin
        req      = (i == 1);
        dev_addr = (i == 1) ? 4'hF : 4'h0;
        ack      = 1'b1;
      end
      #1;
      chk("addr_mvalid", mvalid, (i == 0) ? 1 : 0);
      chk("addr_bit", mwdata, a[i]);
      chk("addr_busy", busy, 1);
      tick();
    end
    req      = 1'b0;
    ack      = 1'b0;
    dev_addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; req = 1'b0; dev_addr = '0; dp_valid = 1'b0; dp_wdata = 1'b0;
    dp_done = 1'b0; ack = 1'b0; ssplit = 1'b0; split_grant = 1'b0;
    #1;
    chk("rst_mvalid", mvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    tick();
    rstn = 1'b1;
    tick();

    // Normal transaction, addr 0010.
    send_addr(4'b0010, 1'b0);
    #1;
    chk("ackw_mvalid", mvalid, 0);
    chk("ackw_conn", connected, 0);
    chk("ackw_busy", busy, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    dp_valid = 1'b1; dp_wdata = 1'b1;
    #1;
    chk("conn_conn", connected, 1);
    chk("conn_mvalid", mvalid, 1);
    chk("conn_mwdata", mwdata, 1);
    dp_valid = 1'b0; dp_wdata = 1'b0;
    #1;
    chk("conn_mvalid0", mvalid, 0);
    chk("conn_mwdata0", mwdata, 0);
    tick(); tick();
    dp_done = 1'b1;
    #1;
    chk("pre_done", done, 0);
    tick();
    dp_done = 1'b0;
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_conn", connected, 0);
    tick();
    #1;
    chk("done_clear", done, 0);

    // Ack timeout, addr 0011.
    send_addr(4'b0011, 1'b0);
    for (int k = 0; k < T; k++) begin
      #1;
      chk("to_wait_err", err, 0);
      chk("to_wait_busy", busy, 1);
      chk("to_wait_conn", connected, 0);
      tick();
    end
    #1;
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_conn", connected, 0);
    tick();
    #1;
    chk("to_err_clear", err, 0);

    // Ack on the last allowed ACKWAIT cycle still connects.
    send_addr(4'b1001, 1'b0);
    tick(); tick(); tick();
    ack = 1'b1;
    #1;
    chk("late_busy", busy, 1);
    tick();
    ack = 1'b0;
    #1;
    chk("late_conn", connected, 1);
    chk("late_err", err, 0);
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    #1;
    chk("late_done", done, 1);
    chk("late_err2", err, 0);

    // Split and resume.
    send_addr(4'b0110, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    dp_valid = 1'b1; dp_wdata = 1'b1; ssplit = 1'b1;
    #1;
    chk("sp_conn_before", connected, 1);
    tick();
    ssplit = 1'b0;
    #1;
    chk("sp_conn", connected, 0);
    chk("sp_mvalid", mvalid, 0);
    chk("sp_mwdata", mwdata, 0);
    chk("sp_busy", busy, 1);
    repeat (5) tick();
    split_grant = 1'b1;
    #1;
    chk("sp_hold_conn", connected, 0);
    tick();
    split_grant = 1'b0;
    #1;
    chk("res_conn", connected, 1);
    chk("res_mvalid", mvalid, 1);
    chk("res_mwdata", mwdata, 1);
    dp_valid = 1'b0; dp_wdata = 1'b0;
    #1;
    chk("res_no_addr", mvalid, 0);
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    #1;
    chk("res_done", done, 1);
    chk("res_busy", busy, 0);

    // dp_done beats a simultaneous ssplit.
    send_addr(4'b0001, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    dp_done = 1'b1; ssplit = 1'b1;
    tick();
    dp_done = 1'b0; ssplit = 1'b0;
    #1;
    chk("sim_done", done, 1);
    chk("sim_busy", busy, 0);
    split_grant = 1'b1;
    tick();
    split_grant = 1'b0;
    #1;
    chk("sim_idle_busy", busy, 0);
    chk("sim_idle_conn", connected, 0);
    chk("sim_done_clear", done, 0);

    // req and ack during ADDR are ignored; captured address must hold.
    send_addr(4'b0100, 1'b1);
    for (int k = 0; k < T; k++) begin
      #1;
      chk("ign_conn", connected, 0);
      tick();
    end
    #1;
    chk("ign_err", err, 1);
    chk("ign_busy", busy, 0);
    tick();
    #1;
    chk("ign_no_second", busy, 0);

    // Asynchronous reset during the third ADDR cycle.
    dev_addr = 4'b0100;
    req = 1'b1;
    tick();
    req = 1'b0;
    dev_addr = '0;
    tick(); tick();
    #1;
    chk("rm_bit2", mwdata, 1);
    chk("rm_busy_pre", busy, 1);
    rstn = 1'b0;
    #1;
    chk("rm_mvalid", mvalid, 0);
    chk("rm_mwdata", mwdata, 0);
    chk("rm_busy", busy, 0);
    tick();
    rstn = 1'b1;
    tick(); tick();
    #1;
    chk("rm_idle_busy", busy, 0);
    chk("rm_idle_mvalid", mvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
